// File: rtl/cache_base_pkg.sv
// Shared types and constants for the base direct-mapped, write-through cache controller.
package cache_base_pkg;

    localparam int CACHE_INDEX_BITS     = 5;
    localparam int CACHE_WORDS_PER_LINE = 16;

    typedef enum logic [3:0] {
        IDLE,
        TAG_CHECK,
        RD_RESP,
        WR_MEM_REQ,
        WR_MEM_WAIT,
        WR_RESP,
        REFILL_REQ,
        REFILL_WAIT,
        REFILL_UPD
    } cache_ctrl_state_t;

endpackage

// File: rtl/cache_base_ctrl_valid_bits.sv
// Per-line valid flags: combinational read by index, synchronous set, async clear on reset.
module cache_valid_bits
    import cache_base_pkg::*;
#(
    parameter int index_bits = CACHE_INDEX_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  set_en,
    input  logic [index_bits-1:0] set_index,
    input  logic [index_bits-1:0] rd_index,
    output logic                  rd_valid
);

    logic [2**index_bits-1:0] valid_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
        end else if (set_en) begin
            valid_q[set_index] <= 1'b1;
        end
    end

    assign rd_valid = valid_q[rd_index];

endmodule

// File: rtl/cache_base_ctrl.sv
// Control FSM for the base cache: tag check, hit response, 16-word refill, write-through.
module cache_base_ctrl
    import cache_base_pkg::*;
#(
    parameter int index_bits     = CACHE_INDEX_BITS,
    parameter int words_per_line = CACHE_WORDS_PER_LINE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  memreq_val,
    output logic                  memreq_rdy,
    output logic                  memresp_val,
    input  logic                  memresp_rdy,
    output logic                  cache_req_val,
    input  logic                  cache_req_rdy,
    input  logic                  cache_resp_val,
    output logic                  cache_resp_rdy,
    input  logic                  tag_array_match,
    input  logic [index_bits-1:0] index,
    input  logic                  read,
    output logic                  data_array_r_en,
    output logic                  data_array_w_en,
    output logic                  data_array_write_mux_sel,
    output logic                  tag_array_w_en,
    output logic                  cache_req_is_refill,
    output logic [4:0]            received_mem_resp_num
);

    localparam logic [4:0] LAST_WORD = 5'(words_per_line - 1);

    cache_ctrl_state_t state, state_nxt;
    logic [4:0]        cnt;
    logic              line_valid;
    logic              hit;
    logic              valid_set;

    cache_valid_bits #(
        .index_bits (index_bits)
    ) u_valid_bits (
        .clk       (clk),
        .reset     (reset),
        .set_en    (valid_set),
        .set_index (index),
        .rd_index  (index),
        .rd_valid  (line_valid)
    );

    assign hit                   = line_valid & tag_array_match;
    assign received_mem_resp_num = cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == TAG_CHECK && state_nxt == REFILL_REQ) begin
                cnt <= '0;
            end else if (state == REFILL_WAIT && cache_resp_val && cnt != LAST_WORD) begin
                cnt <= cnt + 5'd1;
            end
        end
    end

    always_comb begin
        state_nxt                = state;
        memreq_rdy               = 1'b0;
        memresp_val              = 1'b0;
        cache_req_val            = 1'b0;
        cache_resp_rdy           = 1'b0;
        data_array_r_en          = 1'b0;
        data_array_w_en          = 1'b0;
        data_array_write_mux_sel = 1'b0;
        tag_array_w_en           = 1'b0;
        cache_req_is_refill      = 1'b0;
        valid_set                = 1'b0;
        case (state)
            IDLE: begin
                memreq_rdy = 1'b1;
                if (memreq_val) state_nxt = TAG_CHECK;
            end
            TAG_CHECK: begin
                data_array_r_en = 1'b1;
                if (read) begin
                    state_nxt = hit ? RD_RESP : REFILL_REQ;
                end else begin
                    // Write hits update the resident word; misses leave the arrays alone.
                    data_array_w_en = hit;
                    state_nxt       = WR_MEM_REQ;
                end
            end
            RD_RESP: begin
                memresp_val     = 1'b1;
                data_array_r_en = 1'b1;
                if (memresp_rdy) state_nxt = IDLE;
            end
            WR_MEM_REQ: begin
                cache_req_val = 1'b1;
                if (cache_req_rdy) state_nxt = WR_MEM_WAIT;
            end
            WR_MEM_WAIT: begin
                cache_resp_rdy = 1'b1;
                if (cache_resp_val) state_nxt = WR_RESP;
            end
            WR_RESP: begin
                memresp_val = 1'b1;
                if (memresp_rdy) state_nxt = IDLE;
            end
            REFILL_REQ: begin
                cache_req_val       = 1'b1;
                cache_req_is_refill = 1'b1;
                if (cache_req_rdy) state_nxt = REFILL_WAIT;
            end
            REFILL_WAIT: begin
                cache_resp_rdy = 1'b1;
                if (cache_resp_val) begin
                    data_array_w_en          = 1'b1;
                    data_array_write_mux_sel = 1'b1;
                    state_nxt = (cnt == LAST_WORD) ? REFILL_UPD : REFILL_REQ;
                end
            end
            REFILL_UPD: begin
                // Line becomes valid only once every word has landed.
                tag_array_w_en = 1'b1;
                valid_set      = 1'b1;
                state_nxt      = TAG_CHECK;
            end
            default: state_nxt = IDLE;
        endcase
    end

    cache_resp_protocol: assert property (@(posedge clk) disable iff (!reset)
        cache_resp_val |-> (state == WR_MEM_WAIT || state == REFILL_WAIT));

endmodule

// File: tb/tb_cache_base_ctrl.sv
// Bench: emulated datapath and memory around the controller, checked against a line-residency model.
module tb_cache_base_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        memreq_val = 1'b0, memreq_rdy;
    logic        memresp_val, memresp_rdy = 1'b0;
    logic        cache_req_val, cache_req_rdy = 1'b0;
    logic        cache_resp_val = 1'b0, cache_resp_rdy;
    logic        tag_array_match = 1'b0;
    logic [4:0]  index = '0;
    logic        read = 1'b0;
    logic        data_array_r_en, data_array_w_en, data_array_write_mux_sel;
    logic        tag_array_w_en, cache_req_is_refill;
    logic [4:0]  received_mem_resp_num;

    cache_base_ctrl dut (
        .clk                      (clk),
        .reset                    (reset),
        .memreq_val               (memreq_val),
        .memreq_rdy               (memreq_rdy),
        .memresp_val              (memresp_val),
        .memresp_rdy              (memresp_rdy),
        .cache_req_val            (cache_req_val),
        .cache_req_rdy            (cache_req_rdy),
        .cache_resp_val           (cache_resp_val),
        .cache_resp_rdy           (cache_resp_rdy),
        .tag_array_match          (tag_array_match),
        .index                    (index),
        .read                     (read),
        .data_array_r_en          (data_array_r_en),
        .data_array_w_en          (data_array_w_en),
        .data_array_write_mux_sel (data_array_write_mux_sel),
        .tag_array_w_en           (tag_array_w_en),
        .cache_req_is_refill      (cache_req_is_refill),
        .received_mem_resp_num    (received_mem_resp_num)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: which line is resident per index, and what memory holds.
    bit          ref_valid [32];
    logic [20:0] ref_tag   [32];
    logic [31:0] ref_mem   [logic [31:0]];

    // Emulated datapath arrays and memory device.
    logic [20:0] dp_tag  [32];
    logic [31:0] dp_data [32][16];
    logic [31:0] dev_mem [logic [31:0]];

    logic [31:0] lat_addr = '0, lat_wdata = '0;
    logic        lat_read = 1'b0;
    logic [31:0] nxt_addr = '0, nxt_wdata = '0;
    logic        nxt_read = 1'b0;
    bit          want_req = 0, acc = 0, in_txn = 0, resp_done = 0, bp_mode = 0;
    logic [31:0] resp_data;

    bit          mem_pend = 0;
    int          mem_delay = 0;
    logic [31:0] mem_pend_addr = '0;

    int req_stall = 0, req_tgt = 0, resp_stall = 0, resp_tgt = 0;
    bit prev_req_val = 0, prev_req_rdy = 0, prev_req_refill = 0, prev_resp_val = 0, prev_resp_rdy = 0;
    logic [4:0] prev_req_off = '0;

    int n_cyc, n_refill, n_wr, n_dw0, dw0_cyc, n_tagw, n_rdy_bad, n_stable_bad, n_off_bad, first_resp;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [31:0] dev_rd(input logic [31:0] a);
        return dev_mem.exists(a) ? dev_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic int new_tgt();
        return bp_mode ? 5 : int'($urandom_range(0, 2));
    endfunction

    // One clock: drive at negedge, sample 1 time unit later, account for edge transfers.
    task automatic tick();
        int i_idx;
        i_idx           = int'(lat_addr[10:6]);
        index           = lat_addr[10:6];
        read            = lat_read;
        tag_array_match = (dp_tag[i_idx] == lat_addr[31:11]);
        cache_resp_val  = mem_pend && (mem_delay == 0);
        cache_req_rdy   = !mem_pend && (req_stall >= req_tgt);
        memresp_rdy     = (resp_stall >= resp_tgt);
        memreq_val      = want_req || (!memreq_rdy && ($urandom_range(0, 3) == 0));
        #1;
        n_cyc++;
        if (in_txn && memreq_rdy) n_rdy_bad++;
        if (prev_req_val && !prev_req_rdy &&
            (!cache_req_val || cache_req_is_refill != prev_req_refill ||
             received_mem_resp_num != prev_req_off)) n_stable_bad++;
        if (prev_resp_val && !prev_resp_rdy && !memresp_val) n_stable_bad++;
        if (in_txn && memresp_val && first_resp < 0) first_resp = n_cyc;
        if (data_array_w_en && !data_array_write_mux_sel) begin
            n_dw0++;
            dw0_cyc = n_cyc;
            dp_data[i_idx][lat_addr[5:2]] = lat_wdata;
        end
        if (data_array_w_en && data_array_write_mux_sel)
            dp_data[i_idx][received_mem_resp_num[3:0]] = dev_rd(mem_pend_addr);
        if (tag_array_w_en) begin
            n_tagw++;
            dp_tag[i_idx] = lat_addr[31:11];
        end
        if (cache_resp_val && cache_resp_rdy) mem_pend = 0;
        else if (mem_pend && mem_delay > 0) mem_delay--;
        if (cache_req_val && cache_req_rdy) begin
            mem_pend  = 1;
            mem_delay = int'($urandom_range(0, 3));
            if (cache_req_is_refill) begin
                if (received_mem_resp_num != 5'(n_refill)) n_off_bad++;
                mem_pend_addr = {lat_addr[31:6], 6'b0} + 32'({received_mem_resp_num, 2'b00});
                n_refill++;
            end else begin
                n_wr++;
                dev_mem[lat_addr] = lat_wdata;
            end
        end
        if (cache_req_val && !cache_req_rdy) req_stall++;
        else begin
            req_stall = 0;
            if (cache_req_val) req_tgt = new_tgt();
        end
        if (memresp_val && !memresp_rdy) resp_stall++;
        else begin
            resp_stall = 0;
            if (memresp_val) resp_tgt = new_tgt();
        end
        if (memresp_val && memresp_rdy && in_txn) begin
            resp_done = 1;
            resp_data = dp_data[i_idx][lat_addr[5:2]];
            in_txn    = 0;
        end
        if (memreq_val && memreq_rdy) begin
            acc = 1; want_req = 0; in_txn = 1; n_cyc = 0;
            lat_addr = nxt_addr; lat_read = nxt_read; lat_wdata = nxt_wdata;
        end
        prev_req_val    = cache_req_val;
        prev_req_rdy    = cache_req_rdy;
        prev_req_refill = cache_req_is_refill;
        prev_req_off    = received_mem_resp_num;
        prev_resp_val   = memresp_val;
        prev_resp_rdy   = memresp_rdy;
        @(negedge clk);
    endtask

    task automatic start_req(input bit rd, input logic [31:0] addr, input logic [31:0] wd);
        n_refill = 0; n_wr = 0; n_dw0 = 0; dw0_cyc = -1; n_tagw = 0;
        n_rdy_bad = 0; n_stable_bad = 0; n_off_bad = 0; first_resp = -1; n_cyc = 0;
        acc = 0; resp_done = 0;
        nxt_read = rd; nxt_addr = addr; nxt_wdata = wd; want_req = 1;
    endtask

    task automatic do_txn(input bit rd, input logic [31:0] addr, input logic [31:0] wd);
        int  idx;
        bit  hit;
        idx = int'(addr[10:6]);
        hit = ref_valid[idx] && (ref_tag[idx] == addr[31:11]);
        start_req(rd, addr, wd);
        for (int i = 0; i < 20 && !acc; i++) tick();
        check_eq("accept", 32'(acc), 32'd1);
        if (!acc) begin
            want_req = 0;
            return;
        end
        for (int i = 0; i < 3000 && !resp_done; i++) tick();
        check_eq("resp_done", 32'(resp_done), 32'd1);
        check_eq("refill_reqs", 32'(n_refill), (rd && !hit) ? 32'd16 : 32'd0);
        check_eq("refill_offsets_bad", 32'(n_off_bad), 32'd0);
        check_eq("write_reqs", 32'(n_wr), rd ? 32'd0 : 32'd1);
        check_eq("tag_writes", 32'(n_tagw), (rd && !hit) ? 32'd1 : 32'd0);
        check_eq("proc_data_writes", 32'(n_dw0), (!rd && hit) ? 32'd1 : 32'd0);
        check_eq("stability_bad", 32'(n_stable_bad), 32'd0);
        check_eq("memreq_rdy_busy", 32'(n_rdy_bad), 32'd0);
        if (rd) begin
            check_eq("read_data", resp_data, ref_rd(addr));
            if (hit && !bp_mode) check_eq("hit_latency", 32'(first_resp), 32'd2);
            if (!hit) begin
                ref_valid[idx] = 1;
                ref_tag[idx]   = addr[31:11];
            end
        end else begin
            if (hit) check_eq("wr_hit_cycle", 32'(dw0_cyc), 32'd1);
            check_eq("mem_written", dev_rd(addr), wd);
            ref_mem[addr] = wd;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_memreq_rdy"}, 32'(memreq_rdy), 32'd1);
        check_eq({tag, "_outs"},
                 32'({memresp_val, cache_req_val, cache_resp_rdy, data_array_r_en, data_array_w_en,
                      data_array_write_mux_sel, tag_array_w_en, cache_req_is_refill,
                      received_mem_resp_num}), 32'd0);
    endtask

    task automatic reset_mid_refill(input logic [31:0] addr);
        start_req(1'b1, addr, 32'h0);
        for (int i = 0; i < 2000 && n_refill < 8; i++) tick();
        check_eq("reached_word7", 32'(n_refill >= 8), 32'd1);
        reset = 1'b0;
        cache_resp_val = 1'b0; memreq_val = 1'b0; cache_req_rdy = 1'b0; memresp_rdy = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        mem_pend = 0; in_txn = 0; want_req = 0;
        req_stall = 0; resp_stall = 0; req_tgt = 0; resp_tgt = 0;
        prev_req_val = 0; prev_resp_val = 0;
        for (int i = 0; i < 32; i++) ref_valid[i] = 0;
    endtask

    initial begin
        logic [31:0] a;
        for (int i = 0; i < 32; i++) begin
            ref_valid[i] = 0;
            ref_tag[i]   = '0;
            dp_tag[i]    = 21'h1F_FFFF;
            for (int j = 0; j < 16; j++) dp_data[i][j] = '0;
        end
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b1;
        @(negedge clk);

        do_txn(1'b1, 32'h0000_1000, 32'h0);
        do_txn(1'b1, 32'h0000_1004, 32'h0);
        do_txn(1'b0, 32'h0000_1008, 32'hDEAD_BEEF);
        do_txn(1'b1, 32'h0000_1008, 32'h0);
        do_txn(1'b0, 32'h0000_2000, 32'h1234_5678);
        do_txn(1'b1, 32'h0000_2000, 32'h0);
        do_txn(1'b1, 32'h0000_1000, 32'h0);
        do_txn(1'b1, 32'h0000_1800, 32'h0);
        do_txn(1'b1, 32'h0000_1000, 32'h0);

        bp_mode = 1;
        do_txn(1'b1, 32'h0000_3040, 32'h0);
        do_txn(1'b0, 32'h0000_3044, 32'hCAFE_F00D);
        do_txn(1'b1, 32'h0000_3044, 32'h0);
        do_txn(1'b0, 32'h0000_7044, 32'h0BAD_CAFE);
        bp_mode = 0;

        reset_mid_refill(32'h0000_5080);
        do_txn(1'b1, 32'h0000_5080, 32'h0);
        do_txn(1'b1, 32'h0000_3044, 32'h0);

        for (int t = 0; t < 40; t++) begin
            a = {21'($urandom_range(1, 3)), 5'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'b00};
            if ($urandom_range(0, 9) < 6) do_txn(1'b1, a, 32'h0);
            else do_txn(1'b0, a, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
